// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and constants for the reset sequencer
//
// Purpose : sequencer state encoding, lock-loss counter width and a small
//           constant-evaluation helper used to size the shared counter.
// Ports   : none (package).
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2,
        SW_HOLD   = 2'd3
    } seq_state_t;

    localparam int LOCK_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchroniser with synchronous clear
//
// Purpose : brings an asynchronous level into the clk_i domain.
// Ports   : clk_i  - destination clock
//           rst_i  - synchronous active-high clear of both flops
//           d_i    - asynchronous input level
//           q_o    - synchronised level (two cycles of latency)
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta <= 1'b0;
            q_o  <= 1'b0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - PLL-lock filtered, staged per-channel reset sequencer
//
// Purpose : holds all reset channels asserted until PLL lock has been stable
//           for LOCK_FILTER cycles, then releases channel 0..CHANNELS-1 one
//           every STAGE_DELAY cycles. Lock loss or a software request during
//           RELEASE/RUN re-asserts every channel at once.
// Ports   : clk_i           - sequencer clock
//           rst_i           - synchronous active-high reset
//           pll_locked_i    - asynchronous PLL lock level
//           sw_rst_i        - synchronous software reset request
//           rst_o           - per-channel active-high resets, bit 0 released first
//           ready_o         - high only in RUN
//           state_o         - 0 WAIT_LOCK, 1 RELEASE, 2 RUN, 3 SW_HOLD
//           lock_loss_cnt_o - saturating count of lock-loss events
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int LOCK_FILTER = 8,
    parameter int STAGE_DELAY = 16,
    parameter int SW_RST_HOLD = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pll_locked_i,
    input  logic                  sw_rst_i,
    output logic [CHANNELS-1:0]   rst_o,
    output logic                  ready_o,
    output logic [1:0]            state_o,
    output logic [LOCK_CNT_W-1:0] lock_loss_cnt_o
);

    generate
        if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
            $error("rst_seq: CHANNELS must be in 1..16");
        end
        if (LOCK_FILTER < 1) begin : g_bad_lock_filter
            $error("rst_seq: LOCK_FILTER must be >= 1");
        end
        if (STAGE_DELAY < 1) begin : g_bad_stage_delay
            $error("rst_seq: STAGE_DELAY must be >= 1");
        end
        if (SW_RST_HOLD < 1) begin : g_bad_sw_rst_hold
            $error("rst_seq: SW_RST_HOLD must be >= 1");
        end
    endgenerate

    // One counter is shared by the lock filter, the stage delay and the
    // software hold, so it is sized for the largest of the three.
    localparam int CNT_W = $clog2(max3(LOCK_FILTER, STAGE_DELAY, SW_RST_HOLD) + 1);
    localparam int IDX_W = $clog2(CHANNELS) + 1;

    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      LOCK_TC   = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0]      STAGE_TC  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0]      HOLD_TC   = CNT_W'(SW_RST_HOLD - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0]   CH_ONE    = CHANNELS'(1);
    localparam logic [LOCK_CNT_W-1:0] LOSS_ONE  = LOCK_CNT_W'(1);

    logic             lock_s;
    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    sync_2ff u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pll_locked_i),
        .q_o   (lock_s)
    );

    assign state_o = state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= WAIT_LOCK;
            cnt             <= '0;
            idx             <= '0;
            rst_o           <= '1;
            ready_o         <= 1'b0;
            lock_loss_cnt_o <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    rst_o   <= '1;
                    ready_o <= 1'b0;
                    // Any dropout restarts the filter window from zero.
                    if (!lock_s) begin
                        cnt <= '0;
                    end else if (cnt == LOCK_TC) begin
                        state <= RELEASE;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                RELEASE, RUN: begin
                    // Lock loss is checked first so it wins over sw_rst_i.
                    if (!lock_s) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        rst_o   <= '1;
                        ready_o <= 1'b0;
                        if (lock_loss_cnt_o != '1) begin
                            lock_loss_cnt_o <= lock_loss_cnt_o + LOSS_ONE;
                        end
                    end else if (sw_rst_i) begin
                        state   <= SW_HOLD;
                        cnt     <= '0;
                        rst_o   <= '1;
                        ready_o <= 1'b0;
                    end else if (state == RELEASE) begin
                        if (cnt == STAGE_TC) begin
                            cnt   <= '0;
                            idx   <= idx + IDX_ONE;
                            rst_o <= rst_o & ~(CH_ONE << idx);
                            if (idx == LAST_IDX) begin
                                state   <= RUN;
                                ready_o <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end

                SW_HOLD: begin
                    rst_o   <= '1;
                    ready_o <= 1'b0;
                    // A repeated request restarts the hold window.
                    if (sw_rst_i) begin
                        cnt <= '0;
                    end else if (cnt == HOLD_TC) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state   <= WAIT_LOCK;
                    cnt     <= '0;
                    rst_o   <= '1;
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - self-checking bench for rst_seq with a behavioural model
module tb_rst_seq;

    localparam int CH = 4;
    localparam int LF = 8;
    localparam int SD = 16;
    localparam int SH = 32;

    localparam int M_WAIT = 0;
    localparam int M_REL  = 1;
    localparam int M_RUN  = 2;
    localparam int M_HOLD = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll = 1'b0;
    logic          sw  = 1'b0;
    logic [CH-1:0] rst_o;
    logic          ready_o;
    logic [1:0]    state_o;
    logic [7:0]    loss_o;

    rst_seq #(
        .CHANNELS    (CH),
        .LOCK_FILTER (LF),
        .STAGE_DELAY (SD),
        .SW_RST_HOLD (SH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pll_locked_i    (pll),
        .sw_rst_i        (sw),
        .rst_o           (rst_o),
        .ready_o         (ready_o),
        .state_o         (state_o),
        .lock_loss_cnt_o (loss_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: the mode plus "how long" counters measured in
    // cycles (consecutive lock cycles, cycles since release start, cycles
    // since the last software request).
    int m_mode   = M_WAIT;
    int m_stable = 0;
    int m_t      = 0;
    int m_h      = 0;
    int m_loss   = 0;
    bit m_s1     = 0;
    bit m_s2     = 0;
    bit m_valid  = 0;
    int cyc      = -1;

    always @(posedge clk) begin
        bit ls;
        if (rst) begin
            m_mode = M_WAIT; m_stable = 0; m_t = 0; m_h = 0; m_loss = 0;
            m_s1 = 0; m_s2 = 0; cyc = -1; m_valid = 1;
        end else begin
            ls = m_s2;
            m_s2 = m_s1;
            m_s1 = pll;
            cyc++;
            case (m_mode)
                M_WAIT: begin
                    if (ls) begin
                        m_stable++;
                        if (m_stable == LF) begin
                            m_mode = M_REL;
                            m_t = 0;
                        end
                    end else begin
                        m_stable = 0;
                    end
                end
                M_REL, M_RUN: begin
                    if (!ls) begin
                        m_mode = M_WAIT;
                        m_stable = 0;
                        if (m_loss < 255) m_loss++;
                    end else if (sw) begin
                        m_mode = M_HOLD;
                        m_h = 0;
                    end else if (m_mode == M_REL) begin
                        m_t++;
                        if (m_t == SD * CH) m_mode = M_RUN;
                    end
                end
                M_HOLD: begin
                    if (sw) begin
                        m_h = 0;
                    end else begin
                        m_h++;
                        if (m_h == SH) begin
                            m_mode = M_WAIT;
                            m_stable = 0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic logic [CH-1:0] exp_rst();
        logic [CH-1:0] ones;
        ones = '1;
        if (m_mode == M_RUN) return '0;
        if (m_mode == M_REL) return ones << (m_t / SD);
        return ones;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model rst_o",   32'(rst_o),   32'(exp_rst()));
            check("model ready_o", 32'(ready_o), 32'(m_mode == M_RUN));
            check("model state_o", 32'(state_o), 32'(m_mode));
            check("model loss",    32'(loss_o),  32'(m_loss));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; pll = 1'b0; sw = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_cyc reached", 32'(cyc), 32'(n));
    endtask

    task automatic wait_state(input logic [1:0] s);
        int guard;
        guard = 0;
        @(negedge clk);
        while (state_o !== s && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_state reached", 32'(state_o), 32'(s));
    endtask

    initial begin
        int e;
        int s;

        // Clean power-up
        do_reset();
        check("reset rst_o", 32'(rst_o), 32'hF);
        check("reset ready", 32'(ready_o), 32'h0);
        check("reset loss", 32'(loss_o), 32'h0);
        wait_cyc(0); pll = 1'b1;
        wait_cyc(9);  check("pu state@9", 32'(state_o), 32'd0);
        wait_cyc(10); check("pu state@10", 32'(state_o), 32'd1);
        wait_cyc(25); check("pu rst@25", 32'(rst_o), 32'hF);
        wait_cyc(26); check("pu rst@26", 32'(rst_o), 32'hE);
        wait_cyc(42); check("pu rst@42", 32'(rst_o), 32'hC);
        wait_cyc(58); check("pu rst@58", 32'(rst_o), 32'h8);
        wait_cyc(73); check("pu ready@73", 32'(ready_o), 32'h0);
        wait_cyc(74);
        check("pu rst@74", 32'(rst_o), 32'h0);
        check("pu ready@74", 32'(ready_o), 32'h1);
        check("pu state@74", 32'(state_o), 32'd2);

        // Glitchy lock: 5 high, 1 low, then high
        do_reset();
        wait_cyc(0); pll = 1'b1;
        wait_cyc(5); pll = 1'b0;
        wait_cyc(6); pll = 1'b1;
        wait_cyc(15); check("glitch state@15", 32'(state_o), 32'd0);
        wait_cyc(16);
        check("glitch state@16", 32'(state_o), 32'd1);
        check("glitch loss", 32'(loss_o), 32'd0);
        wait_cyc(31); check("glitch rst@31", 32'(rst_o), 32'hF);
        wait_cyc(32); check("glitch rst@32", 32'(rst_o), 32'hE);

        // Lock loss in RUN
        wait_state(2'd2);
        e = cyc;
        pll = 1'b0;
        wait_cyc(e + 1); pll = 1'b1;
        wait_cyc(e + 2); check("loss rst@+2", 32'(rst_o), 32'h0);
        wait_cyc(e + 3);
        check("loss rst@+3", 32'(rst_o), 32'hF);
        check("loss cnt@+3", 32'(loss_o), 32'd1);
        check("loss state@+3", 32'(state_o), 32'd0);
        wait_state(2'd2);
        check("loss resequenced rst", 32'(rst_o), 32'h0);
        check("loss cnt kept", 32'(loss_o), 32'd1);

        // Software reset in RUN, then an extended hold
        e = cyc;
        sw = 1'b1;
        s = e + 1;
        wait_cyc(s); sw = 1'b0;
        wait_cyc(s + 31);
        check("sw state@31", 32'(state_o), 32'd3);
        check("sw rst@31", 32'(rst_o), 32'hF);
        wait_cyc(s + 32); check("sw state@32", 32'(state_o), 32'd0);
        wait_state(2'd2);
        e = cyc;
        sw = 1'b1;
        s = e + 1;
        wait_cyc(s); sw = 1'b0;
        wait_cyc(s + 19); sw = 1'b1;
        wait_cyc(s + 20); sw = 1'b0;
        wait_cyc(s + 51); check("sw2 state@51", 32'(state_o), 32'd3);
        wait_cyc(s + 52); check("sw2 state@52", 32'(state_o), 32'd0);

        // Simultaneous lock loss and sw_rst_i at idx=2
        do_reset();
        wait_cyc(0); pll = 1'b1;
        wait_cyc(47); pll = 1'b0;
        wait_cyc(49);
        check("both state@49", 32'(state_o), 32'd1);
        check("both rst@49", 32'(rst_o), 32'hC);
        sw = 1'b1;
        wait_cyc(50);
        check("both state@50", 32'(state_o), 32'd0);
        check("both loss@50", 32'(loss_o), 32'd1);
        check("both rst@50", 32'(rst_o), 32'hF);
        sw = 1'b0; pll = 1'b1;

        // Saturation
        for (int i = 0; i < 300; i++) begin
            pll = 1'b1;
            repeat (14) @(negedge clk);
            pll = 1'b0;
            repeat (4) @(negedge clk);
        end
        check("loss saturated", 32'(loss_o), 32'd255);

        // rst_i mid-RELEASE
        pll = 1'b1;
        wait_state(2'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst loss", 32'(loss_o), 32'd0);
        check("midrst rst", 32'(rst_o), 32'hF);
        check("midrst state", 32'(state_o), 32'd0);
        check("midrst ready", 32'(ready_o), 32'd0);
        rst = 1'b0;

        // Randomised stimulus against the model
        pll = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (pll) begin
                if ($urandom_range(0, 999) < 5) pll = 1'b0;
            end else begin
                if ($urandom_range(0, 99) < 30) pll = 1'b1;
            end
            sw  = ($urandom_range(0, 999) < 8);
            rst = ($urandom_range(0, 999) < 2);
        end
        @(negedge clk);
        rst = 1'b0; sw = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
